// File: rtl/transform_pkg.sv
// Shared types for the transform arbiter: sample/tag types, arbiter FSM states and the
// transform output-width helper.
package transform_pkg;

    localparam int unsigned SAMPLE_WIDTH = 16;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
    typedef logic tag_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } arb_state_t;

    function automatic int unsigned out_width(input int unsigned width, input int unsigned length);
        return 2 * (width + $clog2(length));
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO of requester tags; records grant order so transform output frames can be
// routed back to the requester that supplied them.
module tag_fifo
    import transform_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    tag_t          mem_q [DEPTH];
    tag_t          mem_d [DEPTH];
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/transform_arbiter.sv
// Frame-granular round-robin sharing of one transform core between two requesters, with
// tag-FIFO routing of results. Optional m*_last / overrun ports: TRANSFORM_ARBITER_LAST_EN.
module transform_arbiter
    import transform_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LENGTH    = 64,
    parameter int unsigned OUT_WIDTH = out_width(WIDTH, LENGTH),
    parameter int unsigned TAGS      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s0_valid,
    output logic                 s0_ready,
    input  logic [2*WIDTH-1:0]   s0_data,
    input  logic                 s1_valid,
    output logic                 s1_ready,
    input  logic [2*WIDTH-1:0]   s1_data,
    output logic                 t_valid,
    input  logic                 t_ready,
    output logic [2*WIDTH-1:0]   t_data,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [OUT_WIDTH-1:0] r_data,
    output logic                 m0_valid,
    input  logic                 m0_ready,
    output logic [OUT_WIDTH-1:0] m0_data,
    output logic                 m1_valid,
    input  logic                 m1_ready,
`ifdef TRANSFORM_ARBITER_LAST_EN
    output logic                 m0_last,
    output logic                 m1_last,
    output logic                 overrun,
`endif
    output logic [OUT_WIDTH-1:0] m1_data
);

    localparam int unsigned CW = $clog2(LENGTH);
    localparam logic [CW-1:0] LAST_BEAT = CW'(LENGTH - 1);

    arb_state_t    state_q, state_d;
    tag_t          rr_q, rr_d;
    tag_t          winner;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          tag_push, tag_pop, tag_full, tag_empty;
    tag_t          tag_head;
    logic          out_fire;

    tag_fifo #(
        .DEPTH(TAGS)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (tag_push),
        .push_tag(winner),
        .pop     (tag_pop),
        .full    (tag_full),
        .empty   (tag_empty),
        .head    (tag_head)
    );

    // Input side: arbitrate in IDLE, then pass one whole frame straight through.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        in_cnt_d = in_cnt_q;
        winner   = 1'b0;
        tag_push = 1'b0;
        t_valid  = 1'b0;
        t_data   = s0_data;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!tag_full && (s0_valid || s1_valid)) begin
                    winner   = (s0_valid && s1_valid) ? rr_q : s1_valid;
                    tag_push = 1'b1;
                    rr_d     = ~winner;
                    state_d  = winner ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                t_valid  = s0_valid;
                s0_ready = t_ready;
            end
            GRANT1: begin
                t_valid  = s1_valid;
                t_data   = s1_data;
                s1_ready = t_ready;
            end
            default: state_d = IDLE;
        endcase
        if (t_valid && t_ready) begin
            if (in_cnt_q == LAST_BEAT) begin
                in_cnt_d = '0;
                state_d  = IDLE;
            end else begin
                in_cnt_d = in_cnt_q + CW'(1);
            end
        end
    end

    // Output side: the FIFO head names the requester owning the frame now leaving the core.
    always_comb begin
        m0_data   = r_data;
        m1_data   = r_data;
        m0_valid  = r_valid && !tag_empty && (tag_head == 1'b0);
        m1_valid  = r_valid && !tag_empty && (tag_head == 1'b1);
        r_ready   = !tag_empty && (tag_head ? m1_ready : m0_ready);
        out_fire  = r_valid && r_ready;
        out_cnt_d = out_cnt_q;
        tag_pop   = 1'b0;
        if (out_fire) begin
            if (out_cnt_q == LAST_BEAT) begin
                out_cnt_d = '0;
                tag_pop   = 1'b1;
            end else begin
                out_cnt_d = out_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

`ifdef TRANSFORM_ARBITER_LAST_EN
    logic overrun_q, overrun_d;

    assign m0_last   = m0_valid && (out_cnt_q == LAST_BEAT);
    assign m1_last   = m1_valid && (out_cnt_q == LAST_BEAT);
    assign overrun_d = overrun_q | (r_valid & tag_empty);
    assign overrun   = overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end
`endif

endmodule

// File: tb/tb_transform_arbiter.sv
// Bench for transform_arbiter: the bench plays both requesters and an echoing transform
// model; expected results are queued per output port as stimulus is issued.
module tb_transform_arbiter;
    import transform_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned L  = 8;
    localparam int unsigned OW = 38;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s0_valid = 1'b0, s0_ready;
    logic [31:0]   s0_data = '0;
    logic          s1_valid = 1'b0, s1_ready;
    logic [31:0]   s1_data = '0;
    logic          t_valid, t_ready = 1'b1;
    logic [31:0]   t_data;
    logic          r_valid = 1'b0, r_ready;
    logic [OW-1:0] r_data = '0;
    logic          m0_valid, m0_ready = 1'b1;
    logic [OW-1:0] m0_data;
    logic          m1_valid, m1_ready = 1'b1;
    logic [OW-1:0] m1_data;
`ifdef TRANSFORM_ARBITER_LAST_EN
    logic          m0_last, m1_last, overrun;
`endif

    transform_arbiter #(
        .WIDTH    (W),
        .LENGTH   (L),
        .OUT_WIDTH(OW),
        .TAGS     (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s0_valid(s0_valid),
        .s0_ready(s0_ready),
        .s0_data (s0_data),
        .s1_valid(s1_valid),
        .s1_ready(s1_ready),
        .s1_data (s1_data),
        .t_valid (t_valid),
        .t_ready (t_ready),
        .t_data  (t_data),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .r_data  (r_data),
        .m0_valid(m0_valid),
        .m0_ready(m0_ready),
        .m0_data (m0_data),
        .m1_valid(m1_valid),
        .m1_ready(m1_ready),
`ifdef TRANSFORM_ARBITER_LAST_EN
        .m0_last (m0_last),
        .m1_last (m1_last),
        .overrun (overrun),
`endif
        .m1_data (m1_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Stimulus sources, transform model and observation logs.
    logic [31:0]   s0_q[$], s1_q[$];
    bit            s0_gap, s1_gap, m0_en = 1'b1, m1_en = 1'b1, r_force;
    logic [31:0]   tf_acc[$];
    logic [OW-1:0] tf_out[$];
    logic [31:0]   t_data_log[$];
    int            t_cyc_log[$];
    bit            t_src_log[$];
    logic [OW-1:0] m0_log[$], m1_log[$];
    int            m0_cyc_log[$];
    bit            m0_last_log[$];
    int            s0_fire_cyc[$], s1_fire_cyc[$];
    int            m1_vcnt;
    logic [31:0]   exp_t[$];
    logic [OW-1:0] exp_m0[$], exp_m1[$];

    function automatic logic [OW-1:0] xf(input logic [31:0] d);
        return {~d[5:0], d};
    endfunction

    task automatic step();
        @(negedge clk);
        s0_valid = (s0_q.size() > 0) && (!s0_gap || cyc[0]);
        s0_data  = (s0_q.size() > 0) ? s0_q[0] : '0;
        s1_valid = (s1_q.size() > 0) && (!s1_gap || cyc[0]);
        s1_data  = (s1_q.size() > 0) ? s1_q[0] : '0;
        r_valid  = (tf_out.size() > 0) || r_force;
        r_data   = (tf_out.size() > 0) ? tf_out[0] : '0;
        m0_ready = m0_en;
        m1_ready = m1_en;
        t_ready  = 1'b1;
        #1;
        if (t_valid && t_ready) begin
            t_data_log.push_back(t_data);
            t_cyc_log.push_back(cyc);
            t_src_log.push_back(s1_valid && s1_ready);
            tf_acc.push_back(t_data);
            if (tf_acc.size() == L) begin
                foreach (tf_acc[i]) tf_out.push_back(xf(tf_acc[i]));
                tf_acc.delete();
            end
        end
        if (s0_valid && s0_ready) begin
            void'(s0_q.pop_front());
            s0_fire_cyc.push_back(cyc);
        end
        if (s1_valid && s1_ready) begin
            void'(s1_q.pop_front());
            s1_fire_cyc.push_back(cyc);
        end
        if (r_valid && r_ready && tf_out.size() > 0) void'(tf_out.pop_front());
        if (m0_valid && m0_ready) begin
            m0_log.push_back(m0_data);
            m0_cyc_log.push_back(cyc);
`ifdef TRANSFORM_ARBITER_LAST_EN
            m0_last_log.push_back(m0_last);
`endif
        end
        if (m1_valid && m1_ready) m1_log.push_back(m1_data);
        if (m1_valid) m1_vcnt++;
        cyc++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        s0_q.delete(); s1_q.delete(); tf_acc.delete(); tf_out.delete();
        t_data_log.delete(); t_cyc_log.delete(); t_src_log.delete();
        m0_log.delete(); m1_log.delete(); m0_cyc_log.delete(); m0_last_log.delete();
        s0_fire_cyc.delete(); s1_fire_cyc.delete();
        exp_t.delete(); exp_m0.delete(); exp_m1.delete();
        s0_gap = 0; s1_gap = 0; m0_en = 1; m1_en = 1; r_force = 0; m1_vcnt = 0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic run_drain(input int budget, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (s0_q.size() != 0 || s1_q.size() != 0 || tf_acc.size() != 0 || tf_out.size() != 0)
        begin
            if (n >= budget) begin
                ok = 1'b0;
                break;
            end
            step();
            n++;
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < L; i++) s0_q.push_back(32'h100 + i);
        step();
        total++;
        if ({s0_ready, s1_ready, t_valid, r_ready, m0_valid, m1_valid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_idle_outputs: got %b want 000000",
                     {s0_ready, s1_ready, t_valid, r_ready, m0_valid, m1_valid});
        end
        step();
        total++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_grant: got s0_ready=%b s1_ready=%b want 1 0",
                     s0_ready, s1_ready);
        end
    endtask

    task automatic test_single();
        sample_t cos_t[8] = '{2048, 1448, 0, -1448, -2048, -1448, 0, 1448};
        sample_t sin_t[8] = '{0, -1448, -2048, -1448, 0, 1448, 2048, 1448};
        logic [31:0] d;
        logic [OW-1:0] e;
        bit ok;
        int src1;
        apply_reset();
        for (int i = 0; i < L; i++) begin
            d = {sin_t[i], cos_t[i]};
            s0_q.push_back(d);
            exp_t.push_back(d);
            exp_m0.push_back(xf(d));
        end
        run_drain(200, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_timeout: frame not drained within budget");
        end
        total++;
        if (t_data_log.size() != L) begin
            bad++;
            $display("FAIL single_t_beats: got %0d want %0d", t_data_log.size(), L);
        end
        src1 = 0;
        for (int i = 0; i < t_src_log.size(); i++) src1 += int'(t_src_log[i]);
        total++;
        if (src1 != 0) begin
            bad++;
            $display("FAIL single_t_source: got %0d s1 beats want 0", src1);
        end
        for (int i = 0; i < L; i++) begin
            total++;
            if (i >= t_data_log.size() || t_data_log[i] !== exp_t[i]) begin
                bad++;
                $display("FAIL single_t_data[%0d]: got %h want %h", i,
                         (i < t_data_log.size()) ? t_data_log[i] : 32'hx, exp_t[i]);
            end
        end
        while (exp_m0.size() > 0) begin
            e = exp_m0.pop_front();
            total++;
            if (m0_log.size() == 0) begin
                bad++;
                $display("FAIL single_m0_missing: got nothing want %h", e);
            end else if (m0_log[0] !== e) begin
                bad++;
                $display("FAIL single_m0_data: got %h want %h", m0_log[0], e);
            end
            if (m0_log.size() > 0) void'(m0_log.pop_front());
        end
        total++;
        if (m1_vcnt != 0) begin
            bad++;
            $display("FAIL single_m1_valid: got %0d valid cycles want 0", m1_vcnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0, d1;
        logic [OW-1:0] e;
        bit ok;
        apply_reset();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < L; i++) begin
                d0 = {8'hA0, 8'(f), 16'(i)};
                s0_q.push_back(d0);
                exp_m0.push_back(xf(d0));
            end
            for (int i = 0; i < L; i++) begin
                d1 = {8'hB1, 8'(f), 16'(i)};
                s1_q.push_back(d1);
                exp_m1.push_back(xf(d1));
            end
            for (int i = 0; i < L; i++) exp_t.push_back({8'hA0, 8'(f), 16'(i)});
            for (int i = 0; i < L; i++) exp_t.push_back({8'hB1, 8'(f), 16'(i)});
        end
        run_drain(400, ok);
        total++;
        if (!ok || t_data_log.size() != 4 * L) begin
            bad++;
            $display("FAIL b2b_t_beats: got %0d beats (drained=%0d) want %0d",
                     t_data_log.size(), ok, 4 * L);
        end else begin
            for (int i = 0; i < 4 * L; i++) begin
                total++;
                if (t_data_log[i] !== exp_t[i] || t_src_log[i] !== bit'((i / L) % 2)) begin
                    bad++;
                    $display("FAIL b2b_t_order[%0d]: got %h src %0d want %h src %0d", i,
                             t_data_log[i], t_src_log[i], exp_t[i], (i / L) % 2);
                end
            end
            for (int f = 0; f < 3; f++) begin
                total++;
                if (t_cyc_log[L*(f+1)] - t_cyc_log[L*f+L-1] != 2) begin
                    bad++;
                    $display("FAIL b2b_bubble[%0d]: got gap %0d cycles want 2", f,
                             t_cyc_log[L*(f+1)] - t_cyc_log[L*f+L-1]);
                end
            end
        end
        while (exp_m0.size() > 0) begin
            e = exp_m0.pop_front();
            total++;
            if (m0_log.size() == 0 || m0_log[0] !== e) begin
                bad++;
                $display("FAIL b2b_m0_data: got %h want %h",
                         (m0_log.size() > 0) ? m0_log[0] : {OW{1'bx}}, e);
            end
            if (m0_log.size() > 0) void'(m0_log.pop_front());
        end
        while (exp_m1.size() > 0) begin
            e = exp_m1.pop_front();
            total++;
            if (m1_log.size() == 0 || m1_log[0] !== e) begin
                bad++;
                $display("FAIL b2b_m1_data: got %h want %h",
                         (m1_log.size() > 0) ? m1_log[0] : {OW{1'bx}}, e);
            end
            if (m1_log.size() > 0) void'(m1_log.pop_front());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [OW-1:0] e;
        bit ok;
        apply_reset();
        m0_en = 1'b0;
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < L; i++) begin
                d = {8'hC0, 8'(f), 16'(i)};
                s0_q.push_back(d);
                exp_m0.push_back(xf(d));
            end
        end
        repeat (80) step();
        total++;
        if (t_data_log.size() != 4 * L) begin
            bad++;
            $display("FAIL bp_held_beats: got %0d t beats want %0d", t_data_log.size(), 4 * L);
        end
        total++;
        if (s0_ready !== 1'b0 || r_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_stalled: got s0_ready=%b r_ready=%b want 0 0", s0_ready, r_ready);
        end
        m0_en = 1'b1;
        run_drain(400, ok);
        total++;
        if (!ok || t_cyc_log.size() != 5 * L || m0_cyc_log.size() < L) begin
            bad++;
            $display("FAIL bp_resume_count: got %0d t beats %0d m0 beats want %0d",
                     t_cyc_log.size(), m0_cyc_log.size(), 5 * L);
        end else begin
            total++;
            if (t_cyc_log[4*L] != m0_cyc_log[L-1] + 2) begin
                bad++;
                $display("FAIL bp_resume_cycle: got first beat at %0d want %0d",
                         t_cyc_log[4*L], m0_cyc_log[L-1] + 2);
            end
        end
        while (exp_m0.size() > 0) begin
            e = exp_m0.pop_front();
            total++;
            if (m0_log.size() == 0 || m0_log[0] !== e) begin
                bad++;
                $display("FAIL bp_m0_data: got %h want %h",
                         (m0_log.size() > 0) ? m0_log[0] : {OW{1'bx}}, e);
            end
            if (m0_log.size() > 0) void'(m0_log.pop_front());
        end
    endtask

    task automatic test_gaps();
        logic [31:0] d;
        logic [OW-1:0] e;
        bit ok;
        int src1;
        apply_reset();
        s1_gap = 1'b1;
        for (int i = 0; i < L; i++) begin
            d = {8'hD1, 8'h00, 16'(i)};
            s1_q.push_back(d);
            exp_m1.push_back(xf(d));
        end
        repeat (3) step();
        for (int i = 0; i < L; i++) begin
            d = {8'hD0, 8'h00, 16'(i)};
            s0_q.push_back(d);
            exp_m0.push_back(xf(d));
        end
        run_drain(300, ok);
        total++;
        if (!ok || s1_fire_cyc.size() != L || s0_fire_cyc.size() != L) begin
            bad++;
            $display("FAIL gaps_counts: got s0=%0d s1=%0d beats want %0d each",
                     s0_fire_cyc.size(), s1_fire_cyc.size(), L);
        end else begin
            total++;
            if (s0_fire_cyc[0] <= s1_fire_cyc[L-1]) begin
                bad++;
                $display("FAIL gaps_hold: got s0 first beat cyc %0d want after %0d",
                         s0_fire_cyc[0], s1_fire_cyc[L-1]);
            end
        end
        src1 = 0;
        for (int i = 0; i < L && i < t_src_log.size(); i++) src1 += int'(t_src_log[i]);
        total++;
        if (src1 != L) begin
            bad++;
            $display("FAIL gaps_first_frame_src: got %0d s1 beats want %0d", src1, L);
        end
        while (exp_m1.size() > 0) begin
            e = exp_m1.pop_front();
            total++;
            if (m1_log.size() == 0 || m1_log[0] !== e) begin
                bad++;
                $display("FAIL gaps_m1_data: got %h want %h",
                         (m1_log.size() > 0) ? m1_log[0] : {OW{1'bx}}, e);
            end
            if (m1_log.size() > 0) void'(m1_log.pop_front());
        end
        total++;
        if (m0_log.size() != L) begin
            bad++;
            $display("FAIL gaps_m0_beats: got %0d want %0d", m0_log.size(), L);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [OW-1:0] e;
        bit ok;
        int n;
        apply_reset();
        for (int i = 0; i < L; i++) s0_q.push_back({8'hE0, 8'h00, 16'(i)});
        n = 0;
        while (t_data_log.size() < 3 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (t_data_log.size() != 3) begin
            bad++;
            $display("FAIL rstmid_progress: got %0d beats want 3", t_data_log.size());
        end
        apply_reset();
        r_force = 1'b1;
        step();
        r_force = 1'b0;
        total++;
        if ({s0_ready, s1_ready, t_valid, r_ready, m0_valid, m1_valid} !== 6'b0) begin
            bad++;
            $display("FAIL rstmid_cleared: got %b want 000000",
                     {s0_ready, s1_ready, t_valid, r_ready, m0_valid, m1_valid});
        end
        for (int i = 0; i < L; i++) begin
            d = {8'hE1, 8'h00, 16'(i)};
            s1_q.push_back(d);
            exp_m1.push_back(xf(d));
        end
        run_drain(200, ok);
        total++;
        if (!ok || t_data_log.size() != L || m0_log.size() != 0) begin
            bad++;
            $display("FAIL rstmid_fresh: got %0d t beats %0d m0 beats (drained=%0d) want %0d 0",
                     t_data_log.size(), m0_log.size(), ok, L);
        end
        while (exp_m1.size() > 0) begin
            e = exp_m1.pop_front();
            total++;
            if (m1_log.size() == 0 || m1_log[0] !== e) begin
                bad++;
                $display("FAIL rstmid_m1_data: got %h want %h",
                         (m1_log.size() > 0) ? m1_log[0] : {OW{1'bx}}, e);
            end
            if (m1_log.size() > 0) void'(m1_log.pop_front());
        end
    endtask

`ifdef TRANSFORM_ARBITER_LAST_EN
    task automatic test_last_overrun();
        bit ok;
        apply_reset();
        for (int i = 0; i < L; i++) s0_q.push_back({8'hF0, 8'h00, 16'(i)});
        run_drain(200, ok);
        total++;
        if (!ok || m0_last_log.size() != L) begin
            bad++;
            $display("FAIL last_beats: got %0d want %0d", m0_last_log.size(), L);
        end else begin
            for (int i = 0; i < L; i++) begin
                total++;
                if (m0_last_log[i] !== (i == L - 1)) begin
                    bad++;
                    $display("FAIL last_flag[%0d]: got %b want %b", i, m0_last_log[i],
                             (i == L - 1));
                end
            end
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clean: got %b want 0", overrun);
        end
        r_force = 1'b1;
        step();
        r_force = 1'b0;
        step();
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set: got %b want 1", overrun);
        end
        repeat (4) step();
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky: got %b want 1", overrun);
        end
        apply_reset();
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_reset: got %b want 0", overrun);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_gaps();
        test_reset_mid();
`ifdef TRANSFORM_ARBITER_LAST_EN
        test_last_overrun();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
